if_id_stage: RTL and testbench

- IF/ID pipeline stage sitting directly downstream of the fetch cycle.
- Captures the fetched Instruction and PC_Next under a valid/ready handshake and holds them stable for decode.
- Includes a one-entry skid buffer, so fetch sees a registered ready.
- Supports a synchronous flush on branch/jump redirect, exposes pre-split instruction fields, and keeps a saturating stall counter for performance debug.

---
 rtl/if_id_stage.sv | 122 ++++++++++++
 tb/tb_if_id_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with a one-entry skid buffer, synchronous redirect flush,
// pre-split instruction fields and a saturating stall counter for performance debug.
`timescale 1ns/1ps

module if_id_stage #(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        Instruction,
  input  logic [XLEN-1:0]        PC_Next,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_instr,
  output logic [XLEN-1:0]        out_pc,
  output logic [5:0]             opcode,
  output logic [4:0]             rs,
  output logic [4:0]             rt,
  output logic [4:0]             rd,
  output logic [15:0]            imm16,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t            state;
  logic            skid_valid;
  logic [XLEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc;
  logic            accept;
  logic            drain;
  logic            stalled;

  assign accept  = in_valid & in_ready;
  assign drain   = out_valid & out_ready;
  assign stalled = out_valid & ~out_ready;

  // in_ready is its own flop, kept equal to ~skid_valid so fetch never sees a
  // combinational path from out_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
      out_instr  <= '0;
      out_pc     <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            out_instr <= Instruction;
            out_pc    <= PC_Next;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            out_instr <= Instruction;
            out_pc    <= PC_Next;
          end else if (accept) begin
            skid_instr <= Instruction;
            skid_pc    <= PC_Next;
            skid_valid <= 1'b1;
            in_ready   <= 1'b0;
            state      <= FULL;
          end else if (drain) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            out_instr  <= skid_instr;
            out_pc     <= skid_pc;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
            state      <= ONE;
          end
        end
        default: begin
          state      <= EMPTY;
          out_valid  <= 1'b0;
          skid_valid <= 1'b0;
          in_ready   <= 1'b1;
        end
      endcase
    end
  end

  // Counts stalled edges even during a flush; sticks at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (stalled && (stall_count != {STALL_CNT_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  assign opcode = out_instr[31:26];
  assign rs     = out_instr[25:21];
  assign rt     = out_instr[20:16];
  assign rd     = out_instr[15:11];
  assign imm16  = out_instr[15:0];

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: scoreboard queue of accepted instructions,
// immediate-assertion checks sampled 1ns after each rising edge.
`timescale 1ns/1ps

module tb_if_id_stage;

  localparam int XLEN        = 32;
  localparam int STALL_CNT_W = 16;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [XLEN-1:0]        Instruction;
  logic [XLEN-1:0]        PC_Next;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [XLEN-1:0]        out_instr;
  logic [XLEN-1:0]        out_pc;
  logic [5:0]             opcode;
  logic [4:0]             rs;
  logic [4:0]             rt;
  logic [4:0]             rd;
  logic [15:0]            imm16;
  logic [STALL_CNT_W-1:0] stall_count;

  int     n_checks = 0;
  int     n_fail   = 0;
  entry_t sb_q[$];

  if_id_stage #(.XLEN(XLEN), .STALL_CNT_W(STALL_CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Instruction(Instruction),
    .PC_Next    (PC_Next),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .opcode     (opcode),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .imm16      (imm16),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one fetch beat; beats expected to be accepted go into the scoreboard.
  task automatic apply_stimulus(input logic valid, input logic [XLEN-1:0] instr,
                                input logic [XLEN-1:0] pc, input logic expect_accept);
    in_valid    = valid;
    Instruction = instr;
    PC_Next     = pc;
    if (valid && expect_accept) sb_q.push_back('{instr: instr, pc: pc});
  endtask

  task automatic check_head(input string tag);
    entry_t e;
    if (sb_q.size() == 0) begin
      check_output({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check_output({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
      check_output({tag, "_instr"}, {32'd0, out_instr}, {32'd0, e.instr});
      check_output({tag, "_pc"}, {32'd0, out_pc}, {32'd0, e.pc});
    end
  endtask

  initial begin
    rst         = 1'b0;
    in_valid    = 1'b0;
    Instruction = '0;
    PC_Next     = '0;
    flush       = 1'b0;
    out_ready   = 1'b0;

    // Reset held for two edges
    tick();
    tick();
    check_output("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_output("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_output("rst_stall", {48'd0, stall_count}, 64'd0);
    check_output("rst_instr", {32'd0, out_instr}, 64'd0);
    rst = 1'b1;
    tick();
    check_output("idle_out_valid", {63'd0, out_valid}, 64'd0);
    check_output("idle_in_ready", {63'd0, in_ready}, 64'd1);

    // Streaming with decode always ready
    out_ready = 1'b1;
    apply_stimulus(1'b1, 32'h11111111, 32'd4, 1'b1);
    tick();
    check_head("stream0");
    check_output("stream0_in_ready", {63'd0, in_ready}, 64'd1);
    apply_stimulus(1'b1, 32'h22222222, 32'd8, 1'b1);
    tick();
    check_head("stream1");
    check_output("stream1_in_ready", {63'd0, in_ready}, 64'd1);
    apply_stimulus(1'b1, 32'h33333333, 32'd12, 1'b1);
    tick();
    check_head("stream2");
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    check_output("stream_done_valid", {63'd0, out_valid}, 64'd0);
    check_output("stream_stall", {48'd0, stall_count}, 64'd0);

    // Backpressure fills main then skid
    out_ready = 1'b0;
    apply_stimulus(1'b1, 32'hAAAA0001, 32'h100, 1'b1);
    tick();
    check_output("bp_a_instr", {32'd0, out_instr}, 64'hAAAA0001);
    check_output("bp_a_stall", {48'd0, stall_count}, 64'd0);
    apply_stimulus(1'b1, 32'hBBBB0002, 32'h104, 1'b1);
    tick();
    check_output("bp_full_in_ready", {63'd0, in_ready}, 64'd0);
    check_output("bp_full_instr", {32'd0, out_instr}, 64'hAAAA0001);
    check_output("bp_full_stall", {48'd0, stall_count}, 64'd1);
    apply_stimulus(1'b1, 32'hCCCC0003, 32'h108, 1'b0);
    tick();
    check_output("bp_hold_instr", {32'd0, out_instr}, 64'hAAAA0001);
    check_output("bp_hold_stall", {48'd0, stall_count}, 64'd2);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0);
    out_ready = 1'b1;
    check_head("bp_drain_a");
    tick();
    check_output("bp_in_ready_back", {63'd0, in_ready}, 64'd1);
    check_head("bp_drain_b");
    tick();
    check_output("bp_empty_valid", {63'd0, out_valid}, 64'd0);
    check_output("bp_end_stall", {48'd0, stall_count}, 64'd2);

    // Fill to FULL, then flush together with an incoming beat
    out_ready = 1'b0;
    apply_stimulus(1'b1, 32'h12340003, 32'h200, 1'b1);
    tick();
    apply_stimulus(1'b1, 32'h12340004, 32'h204, 1'b1);
    tick();
    check_output("pre_flush_in_ready", {63'd0, in_ready}, 64'd0);
    check_output("pre_flush_stall", {48'd0, stall_count}, 64'd3);
    flush = 1'b1;
    apply_stimulus(1'b1, 32'hDEADBEEF, 32'h208, 1'b0);
    tick();
    sb_q.delete();
    check_output("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check_output("flush_in_ready", {63'd0, in_ready}, 64'd1);
    check_output("flush_stall", {48'd0, stall_count}, 64'd4);
    flush = 1'b0;
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    check_output("post_flush_valid", {63'd0, out_valid}, 64'd0);

    // Field split on a lw-style encoding
    apply_stimulus(1'b1, 32'h8C4A0010, 32'h300, 1'b1);
    tick();
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0);
    check_head("field");
    check_output("field_opcode", {58'd0, opcode}, 64'h23);
    check_output("field_rs", {59'd0, rs}, 64'd2);
    check_output("field_rt", {59'd0, rt}, 64'd10);
    check_output("field_rd", {59'd0, rd}, 64'd0);
    check_output("field_imm16", {48'd0, imm16}, 64'h0010);

    // Long stall drives the counter into saturation
    for (int i = 0; i < 70000; i++) tick();
    check_output("sat_stall", {48'd0, stall_count}, 64'hFFFF);
    tick();
    check_output("sat_hold", {48'd0, stall_count}, 64'hFFFF);
    check_output("sat_instr_stable", {32'd0, out_instr}, 64'h8C4A0010);
    check_output("sat_valid", {63'd0, out_valid}, 64'd1);

    // Reset pulsed between edges takes effect without a clock
    #2;
    rst = 1'b0;
    #1;
    check_output("async_valid", {63'd0, out_valid}, 64'd0);
    check_output("async_stall", {48'd0, stall_count}, 64'd0);
    check_output("async_in_ready", {63'd0, in_ready}, 64'd1);
    check_output("async_instr", {32'd0, out_instr}, 64'd0);
    rst = 1'b1;
    tick();
    check_output("after_async_valid", {63'd0, out_valid}, 64'd0);
    check_output("after_async_sb", {32'd0, sb_q.size()}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
